// File: rtl/virtio_pkg.sv
// Shared types for the virtio available-ring scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package virtio_pkg;

    // Upper bound on the number of virtqueues any scheduler instance may serve.
    localparam int MAX_QUEUES = 256;

    // Widest queue index; instances use their own narrower QUEUE_WIDTH.
    typedef logic [$clog2(MAX_QUEUES)-1:0] queue_t;

    // Scheduler FSM: IDLE picks the next winner, OFFER holds it on tx until accepted.
    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } scheduler_state_t;

endpackage

// File: rtl/virtio_round_robin_arbiter.sv
// Round-robin pick: first requesting index strictly after ptr_i, wrapping N-1 -> 0.
// Latency: combinational.
// Backpressure: none; the caller decides when to act on grant_o.
//
// Ports:
//   req_i   [N-1:0]  request vector
//   ptr_i   [W-1:0]  last granted index (search starts at ptr_i+1)
//   grant_o [W-1:0]  winning index (0 when any_o is low)
//   any_o            at least one request present
module virtio_round_robin_arbiter
    import virtio_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] grant_o,
    output logic         any_o
);

    logic [N-1:0] shifted;
    int           idx;

    // Walk distances 1..N from the pointer; distance N lands on ptr_i itself,
    // so a lone request on the last-granted queue is still served.
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        shifted = '0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx     = (int'(ptr_i) + k) % N;
            shifted = req_i >> idx;
            if (!any_o && shifted[0]) begin
                any_o   = 1'b1;
                grant_o = W'(idx);
            end
        end
    end

endmodule

// File: rtl/virtio_available_ring_scheduler.sv
// Coalesces per-queue doorbells into pending bits and issues queue indices round-robin to the ring handler.
// Latency: doorbell at cycle 0 on an idle block -> tx_valid at cycle 2; at most one grant every 2 cycles.
// Backpressure: tx held stable until tx_ready; notify/done always accepted; issue capped at MAX_OUTSTANDING.
//
// Ports:
//   aclk, areset_n                 clock, asynchronous active-low reset
//   enable[QUEUES]                 per-queue enable; falling clears that queue's pending bit
//   notify_valid/_queue/_ready     doorbell channel (ready whenever out of reset)
//   tx_valid/_queue/_ready         service request to the handler
//   done_valid/_queue/_ready       handler completion (ready whenever out of reset)
//   inflight[QUEUES]               queues issued and not yet done
//   error                          sticky: bad done or out-of-range doorbell
module virtio_available_ring_scheduler
    import virtio_pkg::*;
#(
    parameter  int QUEUES          = 4,
    parameter  int MAX_OUTSTANDING = 2,
    localparam int QUEUE_WIDTH     = $clog2(QUEUES)
) (
    input  logic                   aclk,
    input  logic                   areset_n,
    input  logic [QUEUES-1:0]      enable,
    input  logic                   notify_valid,
    input  logic [QUEUE_WIDTH-1:0] notify_queue,
    output logic                   notify_ready,
    output logic                   tx_valid,
    output logic [QUEUE_WIDTH-1:0] tx_queue,
    input  logic                   tx_ready,
    input  logic                   done_valid,
    input  logic [QUEUE_WIDTH-1:0] done_queue,
    output logic                   done_ready,
    output logic [QUEUES-1:0]      inflight,
    output logic                   error
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    // Decode space of a queue index; bits at or above QUEUES flag an out-of-range index.
    localparam int QP    = 1 << QUEUE_WIDTH;

    logic [QUEUES-1:0]      pending_q,  pending_d;
    logic [QUEUES-1:0]      inflight_q, inflight_d;
    logic [CNT_W-1:0]       count_q,    count_d;
    logic [QUEUE_WIDTH-1:0] rr_ptr_q,   rr_ptr_d;
    logic [QUEUE_WIDTH-1:0] tx_queue_q, tx_queue_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   error_q,    error_d;
    scheduler_state_t       state_q,    state_d;

    logic [QP-1:0]          notify_oh, done_oh, grant_oh;
    logic [QUEUES-1:0]      notify_set, done_clr, grant_clr, eligible;
    logic                   notify_bad, done_hit, done_bad, grant_fire, room;
    logic [QUEUE_WIDTH-1:0] arb_idx;
    logic                   arb_any;

    // Both sinks never stall; ready only reflects being out of reset.
    assign notify_ready = areset_n;
    assign done_ready   = areset_n;

    assign notify_oh = QP'(1) << notify_queue;
    assign done_oh   = QP'(1) << done_queue;
    assign grant_oh  = QP'(1) << tx_queue_q;

    // Doorbells to disabled queues vanish; an empty in-range slice means the index was out of range.
    assign notify_set = notify_valid ? (notify_oh[QUEUES-1:0] & enable) : '0;
    assign notify_bad = notify_valid & ~(|notify_oh[QUEUES-1:0]);

    // A done only counts if it names a queue currently in flight.
    assign done_clr = done_valid ? (done_oh[QUEUES-1:0] & inflight_q) : '0;
    assign done_hit = |done_clr;
    assign done_bad = done_valid & ~done_hit;

    assign grant_fire = (state_q == OFFER) & tx_ready;
    assign grant_clr  = grant_fire ? grant_oh[QUEUES-1:0] : '0;

    assign eligible = pending_q & ~inflight_q & enable;
    assign room     = count_q < CNT_W'(MAX_OUTSTANDING);

    virtio_round_robin_arbiter #(
        .N (QUEUES)
    ) u_arb (
        .req_i   (eligible),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_idx),
        .any_o   (arb_any)
    );

    always_comb begin
        // A doorbell landing with its own grant re-arms pending (notify wins over clear),
        // and a disabled queue can never hold pending.
        pending_d  = ((pending_q & ~grant_clr) | notify_set) & enable;
        inflight_d = (inflight_q & ~done_clr) | grant_clr;
        error_d    = error_q | notify_bad | done_bad;

        // Grant and done in the same cycle cancel out; guards keep the counter from wrapping.
        count_d = count_q;
        if (grant_fire && !done_hit && (count_q != CNT_W'(MAX_OUTSTANDING))) begin
            count_d = count_q + CNT_W'(1);
        end else if (!grant_fire && done_hit && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end

        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_queue_d = tx_queue_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (arb_any && room) begin
                    state_d    = OFFER;
                    tx_valid_d = 1'b1;
                    tx_queue_d = arb_idx;
                end
            end
            OFFER: begin
                // Offer is completed even if the queue was disabled meanwhile.
                if (tx_ready) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                    rr_ptr_d   = tx_queue_q;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            pending_q  <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            rr_ptr_q   <= '0;
            tx_queue_q <= '0;
            tx_valid_q <= 1'b0;
            error_q    <= 1'b0;
            state_q    <= IDLE;
        end else begin
            pending_q  <= pending_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_queue_q <= tx_queue_d;
            tx_valid_q <= tx_valid_d;
            error_q    <= error_d;
            state_q    <= state_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_queue = tx_queue_q;
    assign inflight = inflight_q;
    assign error    = error_q;

endmodule

// File: tb/tb_virtio_available_ring_scheduler.sv
// Bench for virtio_available_ring_scheduler: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-level reference model.
// Summary line reports comparisons made and comparisons failed.
module tb_virtio_available_ring_scheduler;

    localparam int Q  = 4;
    localparam int MO = 2;
    localparam int QW = 2;

    logic          aclk = 1'b0;
    logic          areset_n;
    logic [Q-1:0]  enable;
    logic          notify_valid;
    logic [QW-1:0] notify_queue;
    logic          notify_ready;
    logic          tx_valid;
    logic [QW-1:0] tx_queue;
    logic          tx_ready;
    logic          done_valid;
    logic [QW-1:0] done_queue;
    logic          done_ready;
    logic [Q-1:0]  inflight;
    logic          error;

    always #5 aclk = ~aclk;

    virtio_available_ring_scheduler #(
        .QUEUES          (Q),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .aclk         (aclk),
        .areset_n     (areset_n),
        .enable       (enable),
        .notify_valid (notify_valid),
        .notify_queue (notify_queue),
        .notify_ready (notify_ready),
        .tx_valid     (tx_valid),
        .tx_queue     (tx_queue),
        .tx_ready     (tx_ready),
        .done_valid   (done_valid),
        .done_queue   (done_queue),
        .done_ready   (done_ready),
        .inflight     (inflight),
        .error        (error)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per-queue flags, outstanding count, last served queue,
    // the queue currently offered (-1 = nothing offered) and the sticky error.
    bit m_pend[Q];
    bit m_infl[Q];
    int m_cnt;
    int m_last;
    int m_offer;
    bit m_err;
    int grants[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < Q; i++) begin
            m_pend[i] = 1'b0;
            m_infl[i] = 1'b0;
        end
        m_cnt   = 0;
        m_last  = 0;
        m_offer = -1;
        m_err   = 1'b0;
    endtask

    function automatic logic [Q-1:0] model_inflight();
        logic [Q-1:0] v;
        v = '0;
        for (int i = 0; i < Q; i++) v[i] = m_infl[i];
        return v;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit hs, done_ok;
        int nq, dq, next_offer;
        hs      = (m_offer >= 0) && tx_ready;
        nq      = int'(notify_queue);
        dq      = int'(done_queue);
        done_ok = done_valid && (dq < Q) && m_infl[dq];
        if (done_valid && !done_ok) m_err = 1'b1;
        if (notify_valid && nq >= Q) m_err = 1'b1;

        next_offer = m_offer;
        if (hs) begin
            next_offer = -1;
        end else if (m_offer < 0 && m_cnt < MO) begin
            for (int k = 1; k <= Q; k++) begin
                int c;
                c = (m_last + k) % Q;
                if (m_pend[c] && !m_infl[c] && enable[c]) begin
                    next_offer = c;
                    break;
                end
            end
        end

        if (done_ok) begin
            m_infl[dq] = 1'b0;
            m_cnt--;
        end
        if (hs) begin
            grants.push_back(m_offer);
            m_pend[m_offer] = 1'b0;
            m_infl[m_offer] = 1'b1;
            m_cnt++;
            m_last = m_offer;
        end
        if (notify_valid && nq < Q && enable[nq]) m_pend[nq] = 1'b1;
        for (int i = 0; i < Q; i++) if (!enable[i]) m_pend[i] = 1'b0;
        m_offer = next_offer;
    endtask

    task automatic compare();
        chk("tx_valid", 32'(tx_valid), 32'(m_offer >= 0));
        if (m_offer >= 0) chk("tx_queue", 32'(tx_queue), m_offer);
        chk("inflight", 32'(inflight), 32'(model_inflight()));
        chk("error", 32'(error), 32'(m_err));
        chk("notify_ready", 32'(notify_ready), 32'(areset_n));
        chk("done_ready", 32'(done_ready), 32'(areset_n));
    endtask

    task automatic tick();
        model_step();
        @(posedge aclk);
        @(negedge aclk);
        compare();
    endtask

    task automatic notify(input int q);
        notify_valid = 1'b1;
        notify_queue = QW'(q);
        tick();
        notify_valid = 1'b0;
    endtask

    task automatic done(input int q);
        done_valid = 1'b1;
        done_queue = QW'(q);
        tick();
        done_valid = 1'b0;
    endtask

    task automatic wait_grants(input int n, input int budget);
        for (int i = 0; i < budget && grants.size() < n; i++) tick();
        chk("grant_count", grants.size(), n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        areset_n     = 1'b0;
        enable       = '1;
        notify_valid = 1'b0;
        notify_queue = '0;
        tx_ready     = 1'b1;
        done_valid   = 1'b0;
        done_queue   = '0;
        model_reset();

        // Reset state
        @(negedge aclk);
        compare();
        chk("reset_tx_queue", 32'(tx_queue), 0);
        chk("reset_tx_valid", 32'(tx_valid), 0);
        @(negedge aclk);
        areset_n = 1'b1;

        // Single doorbell on q2: tx at cycle 2
        notify(2);
        chk("lat_cycle1_idle", 32'(tx_valid), 0);
        tick();
        chk("lat_cycle2_valid", 32'(tx_valid), 1);
        chk("lat_cycle2_queue", 32'(tx_queue), 2);
        tick();
        chk("single_inflight", 32'(inflight), 32'h4);
        done(2);
        tick();
        chk("single_cleared", 32'(inflight), 0);

        // Round-robin order and outstanding cap
        grants.delete();
        notify(0);
        notify(1);
        notify(3);
        repeat (8) tick();
        chk("cap_grants", grants.size(), 2);
        chk("cap_first", grants[0], 0);
        chk("cap_second", grants[1], 1);
        chk("cap_held", 32'(tx_valid), 0);
        done(0);
        wait_grants(3, 10);
        chk("cap_third", grants[2], 3);
        done(1);
        done(3);
        repeat (3) tick();

        // Coalescing while in flight
        grants.delete();
        notify(1);
        wait_grants(1, 10);
        repeat (5) notify(1);
        repeat (6) tick();
        chk("coalesce_wait_done", grants.size(), 1);
        done(1);
        wait_grants(2, 10);
        chk("coalesce_regrant_q", grants[1], 1);
        done(1);
        repeat (8) tick();
        chk("coalesce_once", grants.size(), 2);

        // Stalled offer, enable dropped mid-stall
        grants.delete();
        tx_ready = 1'b0;
        notify(2);
        tick();
        for (int i = 0; i < 10; i++) begin
            if (i == 4) enable = 4'b1011;
            tick();
            chk("stall_valid", 32'(tx_valid), 1);
            chk("stall_queue", 32'(tx_queue), 2);
        end
        tx_ready = 1'b1;
        tick();
        chk("stall_completed", grants.size(), 1);
        chk("stall_inflight", 32'(inflight), 32'h4);
        done(2);
        enable = '1;
        repeat (6) tick();
        chk("stall_no_repend", grants.size(), 1);

        // Done for a queue not in flight
        grants.delete();
        done(3);
        chk("bad_done_error", 32'(error), 1);
        repeat (5) tick();
        chk("bad_done_sticky", 32'(error), 1);
        // A wrapped count would block both of these grants
        notify(0);
        notify(1);
        wait_grants(2, 12);
        notify(3);
        repeat (3) tick();
        chk("full_held", 32'(tx_valid), 0);
        tx_ready = 1'b0;
        done(0);
        tick();
        chk("offer_before_reset", 32'(tx_valid), 1);

        // Asynchronous reset mid-operation
        #2;
        areset_n = 1'b0;
        #1;
        chk("arst_tx_valid", 32'(tx_valid), 0);
        chk("arst_inflight", 32'(inflight), 0);
        chk("arst_error", 32'(error), 0);
        model_reset();
        @(negedge aclk);
        compare();
        areset_n = 1'b1;
        tx_ready = 1'b1;

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r, pick;
            int live[$];
            r = int'($urandom_range(0, 99));
            if (r < 4) enable = Q'($urandom);
            else if (r < 12) enable = '1;
            notify_valid = ($urandom_range(0, 99) < 40);
            notify_queue = QW'($urandom);
            tx_ready     = ($urandom_range(0, 99) < 60);
            live.delete();
            for (int i = 0; i < Q; i++) if (m_infl[i]) live.push_back(i);
            done_valid = 1'b0;
            r = int'($urandom_range(0, 199));
            if (live.size() > 0 && r < 60) begin
                pick       = live[$urandom_range(0, live.size() - 1)];
                done_valid = 1'b1;
                done_queue = QW'(pick);
            end else if (r == 199) begin
                for (int i = 0; i < Q; i++) begin
                    if (!m_infl[i]) begin
                        done_valid = 1'b1;
                        done_queue = QW'(i);
                    end
                end
            end
            tick();
        end
        notify_valid = 1'b0;
        done_valid   = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
